// File: rtl/cache_mem_arbiter_if.sv
// Cache-to-memory bus: icache/dcache request side plus the single-port RAM side.
// slave is the arbiter's view; master is the view of whatever drives caches and RAM.
interface cache_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          iREN;
  logic [AW-1:0] iaddr;
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dstore;
  logic          iwait;
  logic          dwait;
  logic [DW-1:0] iload;
  logic [DW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic          ram_ready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Serialises icache reads and dcache reads/writes onto one single-port RAM,
// round-robin on conflict, with a one-cycle wait-low acknowledge per request.
module cache_mem_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CPUID = 0
) (
  input logic                CLK,
  input logic                nRST,
  cache_mem_arbiter_if.slave bus
);
  localparam int CPUID_UNUSED = CPUID;

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  state_t        state, state_n;
  logic          last_d, last_d_n;
  logic          dreq;
  logic          iwait_q, dwait_q, ren_q, wen_q;
  logic [DW-1:0] iload_q, dload_q, store_q;
  logic [AW-1:0] addr_q;

  assign dreq = bus.dREN | bus.dWEN;

  // D wins a conflict unless it also won the previous grant
  always_comb begin
    state_n  = state;
    last_d_n = last_d;
    unique case (state)
      IDLE: begin
        if (dreq && (!bus.iREN || !last_d)) begin
          state_n  = BUSY_D;
          last_d_n = 1'b1;
        end else if (bus.iREN) begin
          state_n  = BUSY_I;
          last_d_n = 1'b0;
        end
      end
      BUSY_I:  if (bus.ram_ready) state_n = RESP_I;
      BUSY_D:  if (bus.ram_ready) state_n = RESP_D;
      RESP_I,
      RESP_D:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_n;
      last_d <= last_d_n;
    end
  end

  // Outputs are registered off the next state so the ack lands in the RESP cycle
  always_ff @(posedge CLK) begin
    if (nRST) begin
      iwait_q <= 1'b1;
      dwait_q <= 1'b1;
      iload_q <= '0;
      dload_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      iwait_q <= (state_n != RESP_I);
      dwait_q <= (state_n != RESP_D);
      if (state == IDLE && state_n == BUSY_I) begin
        ren_q  <= 1'b1;
        wen_q  <= 1'b0;
        addr_q <= bus.iaddr;
      end else if (state == IDLE && state_n == BUSY_D) begin
        // a write takes precedence when dREN and dWEN are both raised
        ren_q  <= ~bus.dWEN;
        wen_q  <= bus.dWEN;
        addr_q <= bus.daddr;
        if (bus.dWEN) store_q <= bus.dstore;
      end else if ((state == BUSY_I || state == BUSY_D) && bus.ram_ready) begin
        ren_q <= 1'b0;
        wen_q <= 1'b0;
        if (state == BUSY_I)  iload_q <= bus.ramload;
        else if (!wen_q)      dload_q <= bus.ramload;
      end
    end
  end

  assign bus.iwait    = iwait_q;
  assign bus.dwait    = dwait_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
endmodule
